regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Two writers share the port: the pipeline WB stage (P) and a multi-cycle
// unit (M). P normally has priority. After STARVE_MAX consecutive lost cycles,
// M is forced through on the next cycle. The arbitration decision is
// combinational, and the write to the register file is registered one cycle
// later. Writes to $0 are handshaken but never issued.
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [4:0]        p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_flush,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [4:0]        m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        starve_cnt
);

  typedef enum logic {P_PRI, M_FORCE} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic p_act;
  logic p_win;
  logic m_win;

  // Pick this cycle's winner; a flushed P request does not compete.
  always_comb begin
    p_act = p_valid & ~p_flush;
    p_win = 1'b0;
    m_win = 1'b0;
    if (!rst) begin
      if (state_q == M_FORCE) begin
        m_win = m_valid;
        p_win = p_act & ~m_valid;
      end else begin
        p_win = p_act;
        m_win = ~p_act & m_valid;
      end
    end
  end

  assign p_ready = ~rst & (p_win | ~p_act);
  assign m_ready = m_win;

  // Next starvation count, next FSM state, and the write to issue next cycle.
  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (m_win || !m_valid) begin
      cnt_d = 4'd0;
    end else if (cnt_q < STARVE_LIM) begin
      cnt_d = cnt_q + 4'd1;
    end

    case (state_q)
      P_PRI:   if (cnt_d == STARVE_LIM) state_d = M_FORCE;
      M_FORCE: if (m_win || !m_valid) state_d = P_PRI;
      default: state_d = P_PRI;
    endcase

    // Address and data hold unless a real (non-$0) write is issued.
    if (m_win && m_addr != 5'd0) begin
      wr_en_d   = 1'b1;
      wr_addr_d = m_addr;
      wr_data_d = m_data;
    end else if (p_win && p_addr != 5'd0) begin
      wr_en_d   = 1'b1;
      wr_addr_d = p_addr;
      wr_data_d = p_data;
    end
  end

  // State and registered write-port outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= P_PRI;
      cnt_q     <= 4'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign starve_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (DATA_W=32, STARVE_MAX=3).
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic        p_valid, p_ready, p_flush;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        m_valid, m_ready;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  starve_cnt;

  int n_total = 0;
  int n_pass  = 0;

  regfile_write_arbiter #(.DATA_W(32), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr), .p_data(p_data),
    .p_flush(p_flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .starve_cnt(starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, pv, pf;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_pr, e_mr;   // ready values during the cycle
    logic [3:0]  e_cnt0;       // starve_cnt during the cycle
    logic        e_we;         // registered outputs after the edge
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [3:0]  e_cnt1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle (called just after a rising edge), check the ready
  // outputs mid-cycle and the registered outputs just after the next edge.
  task automatic step(input vec_t v);
    rst = v.rst; p_valid = v.pv; p_flush = v.pf; p_addr = v.pa; p_data = v.pd;
    m_valid = v.mv; m_addr = v.ma; m_data = v.md;
    @(negedge clk);
    chk({v.name, ".p_ready"}, 32'(p_ready), 32'(v.e_pr));
    chk({v.name, ".m_ready"}, 32'(m_ready), 32'(v.e_mr));
    chk({v.name, ".cnt_pre"}, 32'(starve_cnt), 32'(v.e_cnt0));
    @(posedge clk);
    #1;
    chk({v.name, ".wr_en"},   32'(wr_en), 32'(v.e_we));
    chk({v.name, ".wr_addr"}, 32'(wr_addr), 32'(v.e_wa));
    chk({v.name, ".wr_data"}, wr_data, v.e_wd);
    chk({v.name, ".cnt_post"}, 32'(starve_cnt), 32'(v.e_cnt1));
  endtask

  initial begin
    rst = 1'b1; p_valid = 1'b0; p_flush = 1'b0; p_addr = '0; p_data = '0;
    m_valid = 1'b0; m_addr = '0; m_data = '0;
    @(posedge clk);
    #1;

    // Single-cycle table, applied back to back from reset.
    //           name      rst pv pf pa     pd            mv ma     md            pr mr c0 we wa     wd            c1
    vecs.push_back('{"reset", 1, 1, 0, 5'd4, 32'h1234_5678, 1, 5'd6, 32'h8765_4321, 0, 0, 0, 0, 5'd0, 32'h0,        0});
    vecs.push_back('{"idle",  0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         1, 0, 0, 0, 5'd0, 32'h0,        0});
    vecs.push_back('{"p_only",0, 1, 0, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0,         1, 0, 0, 1, 5'd5, 32'hDEAD_BEEF,0});
    vecs.push_back('{"m_r0",  0, 0, 0, 5'd0, 32'h0,         1, 5'd0, 32'h11,        1, 1, 0, 0, 5'd5, 32'hDEAD_BEEF,0});
    vecs.push_back('{"flush", 0, 1, 1, 5'd7, 32'h77,        1, 5'd12,32'h00C0_FFEE, 1, 1, 0, 1, 5'd12,32'h00C0_FFEE,0});
    vecs.push_back('{"same_a",0, 1, 0, 5'd3, 32'h33,        1, 5'd3, 32'h44,        1, 0, 0, 1, 5'd3, 32'h33,       1});
    vecs.push_back('{"p_r0",  0, 1, 0, 5'd0, 32'h55,        0, 5'd3, 32'h44,        1, 0, 1, 0, 5'd3, 32'h33,       0});
    vecs.push_back('{"m_late",0, 0, 0, 5'd0, 32'h0,        1, 5'd3, 32'h44,        1, 1, 0, 1, 5'd3, 32'h44,       0});
    vecs.push_back('{"p_r31", 0, 1, 0, 5'd31,32'hFFFF_FFFF, 0, 5'd0, 32'h0,         1, 0, 0, 1, 5'd31,32'hFFFF_FFFF,0});
    foreach (vecs[i]) step(vecs[i]);

    // Starvation: M loses three cycles, is then forced through, P resumes.
    step('{"starve1", 0, 1, 0, 5'd1, 32'hA1, 1, 5'd9, 32'h99, 1, 0, 0, 1, 5'd1, 32'hA1, 1});
    step('{"starve2", 0, 1, 0, 5'd1, 32'hA2, 1, 5'd9, 32'h99, 1, 0, 1, 1, 5'd1, 32'hA2, 2});
    step('{"starve3", 0, 1, 0, 5'd1, 32'hA3, 1, 5'd9, 32'h99, 1, 0, 2, 1, 5'd1, 32'hA3, 3});
    step('{"forced",  0, 1, 0, 5'd1, 32'hA4, 1, 5'd9, 32'h99, 0, 1, 3, 1, 5'd9, 32'h99, 0});
    step('{"resume",  0, 1, 0, 5'd1, 32'hA4, 1, 5'd9, 32'h9A, 1, 0, 0, 1, 5'd1, 32'hA4, 1});
    step('{"pre_rst", 0, 1, 0, 5'd2, 32'hB0, 1, 5'd9, 32'h9A, 1, 0, 1, 1, 5'd2, 32'hB0, 2});

    // Reset with count at 2 and both requesters valid.
    step('{"mid_rst", 1, 1, 0, 5'd2, 32'hB1, 1, 5'd9, 32'h9A, 0, 0, 2, 0, 5'd0, 32'h0,  0});
    step('{"post_rst",0, 1, 0, 5'd2, 32'hB1, 1, 5'd9, 32'h9A, 1, 0, 0, 1, 5'd2, 32'hB1, 1});

    // Enter M_FORCE, then M withdraws: P wins and priority returns to P.
    step('{"st2",     0, 1, 0, 5'd2, 32'hB2, 1, 5'd9, 32'h9A, 1, 0, 1, 1, 5'd2, 32'hB2, 2});
    step('{"st3",     0, 1, 0, 5'd2, 32'hB3, 1, 5'd9, 32'h9A, 1, 0, 2, 1, 5'd2, 32'hB3, 3});
    step('{"m_gone",  0, 1, 0, 5'd2, 32'h22, 0, 5'd9, 32'h9A, 1, 0, 3, 1, 5'd2, 32'h22, 0});
    step('{"p_back",  0, 1, 0, 5'd8, 32'h88, 1, 5'd9, 32'h9B, 1, 0, 0, 1, 5'd8, 32'h88, 1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
